// File: rtl/spi_cmd_sequencer.sv
// Command sequencer between the SPI byte slave and the LED frame RAM / renderer.
// Decodes address/data/commit/status commands and drives RAM writes, frame start and MISO response.
module spi_cmd_sequencer #(
  parameter int unsigned ADDR_W     = 10,
  parameter logic [7:0]  CMD_ADDR   = 8'h2A,
  parameter logic [7:0]  CMD_DATA   = 8'h2C,
  parameter logic [7:0]  CMD_COMMIT = 8'h3A,
  parameter logic [7:0]  CMD_STATUS = 8'h0F
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              spi_cs_n_i,
  input  logic              spi_byte_vld_i,
  input  logic [7:0]        spi_byte_data_i,
  output logic [7:0]        spi_byte_data_o,
  output logic              ram_wr_en_o,
  output logic [ADDR_W-1:0] ram_wr_addr_o,
  output logic [7:0]        ram_wr_data_o,
  input  logic              render_busy_i,
  output logic              frame_start_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_DATA,
    S_DISCARD
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-9:0] addr_hi_q;
  logic              pending_q;
  logic              err_q;
  logic [7:0]        resp_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic              frame_start_q;

  logic              start_fire;
  logic [7:0]        status_byte;

  assign start_fire  = pending_q && !render_busy_i;
  assign status_byte = {render_busy_i, pending_q, 5'b0, err_q};

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      addr_hi_q     <= '0;
      pending_q     <= 1'b0;
      err_q         <= 1'b0;
      resp_q        <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      wr_en_q       <= 1'b0;
      frame_start_q <= start_fire;
      if (start_fire) pending_q <= 1'b0;
      if (spi_cs_n_i || spi_byte_vld_i) resp_q <= '0;

      if (spi_cs_n_i) begin
        state_q <= S_IDLE;
      end else if (spi_byte_vld_i) begin
        case (state_q)
          S_IDLE: begin
            case (spi_byte_data_i)
              CMD_ADDR: state_q <= S_ADDR_HI;
              CMD_DATA: state_q <= S_DATA;
              CMD_COMMIT: begin
                // a commit landing on the firing cycle is absorbed by that start
                if (!start_fire) pending_q <= 1'b1;
                state_q <= S_DISCARD;
              end
              CMD_STATUS: begin
                resp_q  <= status_byte;
                err_q   <= 1'b0;
                state_q <= S_DISCARD;
              end
              default: begin
                err_q   <= 1'b1;
                state_q <= S_DISCARD;
              end
            endcase
          end
          S_ADDR_HI: begin
            addr_hi_q <= spi_byte_data_i[ADDR_W-9:0];
            state_q   <= S_ADDR_LO;
          end
          S_ADDR_LO: begin
            addr_q  <= {addr_hi_q, spi_byte_data_i};
            state_q <= S_IDLE;
          end
          S_DATA: begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr_q;
            wr_data_q <= spi_byte_data_i;
            addr_q    <= addr_q + ADDR_W'(1);
          end
          S_DISCARD: state_q <= S_DISCARD;
          default:   state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign spi_byte_data_o = resp_q;
  assign ram_wr_en_o     = wr_en_q;
  assign ram_wr_addr_o   = wr_addr_q;
  assign ram_wr_data_o   = wr_data_q;
  assign frame_start_o   = frame_start_q;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Bench for spi_cmd_sequencer: directed vector table, hand-written commit/reset sequences,
// and randomized CS frames checked against a command-level reference model.
module tb_spi_cmd_sequencer;

  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cs_n;
  logic              vld;
  logic [7:0]        din;
  logic [7:0]        dout;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              fstart;

  spi_cmd_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .spi_cs_n_i     (cs_n),
    .spi_byte_vld_i (vld),
    .spi_byte_data_i(din),
    .spi_byte_data_o(dout),
    .ram_wr_en_o    (wr_en),
    .ram_wr_addr_o  (wr_addr),
    .ram_wr_data_o  (wr_data),
    .render_busy_i  (busy),
    .frame_start_o  (fstart)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Drive one cycle of inputs, then sample outputs 1 time unit after the clock edge.
  task automatic apply(input logic c, input logic v, input logic [7:0] b, input logic bz);
    cs_n = c; vld = v; din = b; busy = bz;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic       cs_n;
    logic       vld;
    logic [7:0] b;
    logic       busy;
    logic       en;
    logic [9:0] addr;
    logic [7:0] wd;
    logic [7:0] dout;
    logic       fs;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic c, input logic v, input logic [7:0] b, input logic bz,
                              input logic en, input logic [9:0] a, input logic [7:0] wd,
                              input logic [7:0] d);
    vec_t r;
    r.cs_n = c; r.vld = v; r.b = b; r.busy = bz;
    r.en = en; r.addr = a; r.wd = wd; r.dout = d; r.fs = 1'b0;
    vecs.push_back(r);
  endfunction

  // Reference model: tracks the command byte of the current frame and how many bytes followed it.
  int         m_addr, m_hi, m_cnt;
  bit         m_active, m_pending, m_err;
  logic [7:0] m_cmd, m_resp;
  bit         e_en, e_fs;
  int         e_addr;
  logic [7:0] e_wd;

  function automatic void model_reset();
    m_addr = 0; m_hi = 0; m_cnt = 0; m_active = 0; m_pending = 0; m_err = 0;
    m_cmd = 8'h00; m_resp = 8'h00;
  endfunction

  function automatic void model_step(input bit c, input bit v, input logic [7:0] b, input bit bz);
    logic [7:0] status;
    bit next_pending;
    status = {bz, m_pending, 5'b0, m_err};
    e_en = 0;
    e_fs = m_pending && !bz;
    next_pending = e_fs ? 1'b0 : m_pending;
    if (c) begin
      m_active = 0;
      m_resp = 8'h00;
    end else if (v) begin
      m_resp = 8'h00;
      if (!m_active) begin
        m_active = 1; m_cmd = b; m_cnt = 0;
        if (b == 8'h3A) next_pending = !e_fs;
        else if (b == 8'h0F) begin m_resp = status; m_err = 0; end
        else if (b != 8'h2A && b != 8'h2C) m_err = 1;
      end else begin
        m_cnt++;
        if (m_cmd == 8'h2A) begin
          if (m_cnt == 1) m_hi = b;
          else begin
            m_addr = (m_hi * 256 + b) % 1024;
            m_active = 0;
          end
        end else if (m_cmd == 8'h2C) begin
          e_en = 1; e_addr = m_addr; e_wd = b;
          m_addr = (m_addr + 1) % 1024;
        end
      end
    end
    m_pending = next_pending;
  endfunction

  task automatic rcycle(input logic c, input logic v, input logic [7:0] b, input logic bz);
    model_step(c, v, b, bz);
    apply(c, v, b, bz);
    chk("rnd.wr_en", wr_en, e_en);
    if (e_en) begin
      chk("rnd.wr_addr", wr_addr, e_addr);
      chk("rnd.wr_data", wr_data, e_wd);
    end
    chk("rnd.dout", dout, m_resp);
    chk("rnd.frame_start", fstart, e_fs);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    apply(1'b1, 1'b0, 8'h00, 1'b0);
    apply(1'b1, 1'b0, 8'h00, 1'b0);
    chk("rst.wr_en", wr_en, 0);
    chk("rst.wr_addr", wr_addr, 0);
    chk("rst.wr_data", wr_data, 0);
    chk("rst.dout", dout, 0);
    chk("rst.frame_start", fstart, 0);
    rst_n = 1'b1;
    model_reset();
  endtask

  logic rbusy;
  int   pulses;

  initial begin
    rst_n = 1'b0; cs_n = 1'b1; vld = 1'b0; din = 8'h00; busy = 1'b0;

    // cs_n vld byte busy | en addr wd dout
    add(0, 0, 8'h00, 0, 0, 10'h000, 8'h00, 8'h00);
    add(0, 1, 8'h2A, 0, 0, 10'h000, 8'h00, 8'h00);
    add(0, 1, 8'h01, 0, 0, 10'h000, 8'h00, 8'h00);
    add(0, 1, 8'h23, 0, 0, 10'h000, 8'h00, 8'h00);
    add(1, 0, 8'h00, 0, 0, 10'h000, 8'h00, 8'h00);
    add(0, 1, 8'h2C, 0, 0, 10'h000, 8'h00, 8'h00);
    add(0, 1, 8'h5A, 0, 1, 10'h123, 8'h5A, 8'h00);
    add(0, 0, 8'h00, 0, 0, 10'h000, 8'h00, 8'h00);
    add(1, 0, 8'h00, 0, 0, 10'h000, 8'h00, 8'h00);
    add(0, 1, 8'h2A, 0, 0, 10'h000, 8'h00, 8'h00);
    add(0, 1, 8'h03, 0, 0, 10'h000, 8'h00, 8'h00);
    add(0, 1, 8'hFE, 0, 0, 10'h000, 8'h00, 8'h00);
    add(1, 0, 8'h00, 0, 0, 10'h000, 8'h00, 8'h00);
    add(0, 1, 8'h2C, 0, 0, 10'h000, 8'h00, 8'h00);
    add(0, 1, 8'hAA, 0, 1, 10'h3FE, 8'hAA, 8'h00);
    add(0, 1, 8'hBB, 0, 1, 10'h3FF, 8'hBB, 8'h00);
    add(0, 1, 8'hCC, 0, 1, 10'h000, 8'hCC, 8'h00);
    add(1, 0, 8'h00, 0, 0, 10'h000, 8'h00, 8'h00);
    add(0, 1, 8'h55, 0, 0, 10'h000, 8'h00, 8'h00);
    add(1, 0, 8'h00, 0, 0, 10'h000, 8'h00, 8'h00);
    add(0, 1, 8'h0F, 0, 0, 10'h000, 8'h00, 8'h01);
    add(0, 0, 8'h00, 0, 0, 10'h000, 8'h00, 8'h01);
    add(1, 0, 8'h00, 0, 0, 10'h000, 8'h00, 8'h00);
    add(0, 1, 8'h0F, 0, 0, 10'h000, 8'h00, 8'h00);
    add(1, 0, 8'h00, 0, 0, 10'h000, 8'h00, 8'h00);
    add(0, 1, 8'h0F, 1, 0, 10'h000, 8'h00, 8'h80);
    add(0, 1, 8'h77, 0, 0, 10'h000, 8'h00, 8'h00);
    add(1, 0, 8'h00, 0, 0, 10'h000, 8'h00, 8'h00);
    add(0, 1, 8'h2A, 0, 0, 10'h000, 8'h00, 8'h00);
    add(0, 1, 8'h01, 0, 0, 10'h000, 8'h00, 8'h00);
    add(1, 0, 8'h00, 0, 0, 10'h000, 8'h00, 8'h00);
    add(0, 1, 8'h2C, 0, 0, 10'h000, 8'h00, 8'h00);
    add(0, 1, 8'h11, 0, 1, 10'h001, 8'h11, 8'h00);
    add(1, 0, 8'h00, 0, 0, 10'h000, 8'h00, 8'h00);
    add(1, 1, 8'h2C, 0, 0, 10'h000, 8'h00, 8'h00);
    add(0, 1, 8'h22, 0, 0, 10'h000, 8'h00, 8'h00);
    add(1, 0, 8'h00, 0, 0, 10'h000, 8'h00, 8'h00);
    add(0, 1, 8'h0F, 0, 0, 10'h000, 8'h00, 8'h01);
    add(1, 0, 8'h00, 0, 0, 10'h000, 8'h00, 8'h00);

    do_reset();

    foreach (vecs[i]) begin
      apply(vecs[i].cs_n, vecs[i].vld, vecs[i].b, vecs[i].busy);
      chk($sformatf("vec%0d.wr_en", i), wr_en, vecs[i].en);
      if (vecs[i].en) begin
        chk($sformatf("vec%0d.wr_addr", i), wr_addr, vecs[i].addr);
        chk($sformatf("vec%0d.wr_data", i), wr_data, vecs[i].wd);
      end
      chk($sformatf("vec%0d.dout", i), dout, vecs[i].dout);
      chk($sformatf("vec%0d.frame_start", i), fstart, vecs[i].fs);
    end

    // Two commits while the renderer is busy collapse into one start once it goes idle.
    apply(0, 1, 8'h3A, 1); chk("commit1.fs", fstart, 0);
    apply(1, 0, 8'h00, 1); chk("commit1.cs.fs", fstart, 0);
    apply(0, 1, 8'h3A, 1); chk("commit2.fs", fstart, 0);
    apply(1, 0, 8'h00, 1); chk("commit2.cs.fs", fstart, 0);
    apply(0, 1, 8'h0F, 1); chk("commit.status", dout, 8'hC0);
    apply(1, 0, 8'h00, 1); chk("commit.busy.fs", fstart, 0);
    apply(1, 0, 8'h00, 0); chk("commit.start", fstart, 1);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      apply(1, 0, 8'h00, 0);
      if (fstart) pulses++;
    end
    chk("commit.extra_pulses", pulses, 0);
    apply(0, 1, 8'h0F, 0); chk("commit.status_after", dout, 8'h00);
    apply(1, 0, 8'h00, 0);

    // Reset in the middle of a data stream clears outputs and the address.
    apply(0, 1, 8'h2A, 0); apply(0, 1, 8'h02, 0); apply(0, 1, 8'h00, 0);
    apply(1, 0, 8'h00, 0);
    apply(0, 1, 8'h2C, 0);
    apply(0, 1, 8'h33, 0);
    chk("middata.wr_en", wr_en, 1);
    chk("middata.wr_addr", wr_addr, 10'h200);
    rst_n = 1'b0;
    apply(0, 1, 8'h44, 0);
    chk("middata.rst.wr_en", wr_en, 0);
    chk("middata.rst.wr_addr", wr_addr, 0);
    chk("middata.rst.wr_data", wr_data, 0);
    rst_n = 1'b1;
    apply(1, 0, 8'h00, 0);
    apply(0, 1, 8'h2C, 0);
    apply(0, 1, 8'h66, 0);
    chk("postrst.wr_en", wr_en, 1);
    chk("postrst.wr_addr", wr_addr, 10'h000);
    chk("postrst.wr_data", wr_data, 8'h66);
    apply(1, 0, 8'h00, 0);

    // Randomized CS frames against the reference model.
    do_reset();
    rbusy = 1'b0;
    for (int f = 0; f < 120; f++) begin
      int nb;
      nb = $urandom_range(1, 6);
      for (int j = 0; j < nb; j++) begin
        logic [7:0] b;
        int r;
        b = 8'($urandom);
        if (j == 0) begin
          r = $urandom_range(0, 9);
          if (r < 3) b = 8'h2A;
          else if (r < 6) b = 8'h2C;
          else if (r == 6) b = 8'h3A;
          else if (r == 7) b = 8'h0F;
        end
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          if ($urandom_range(0, 3) == 0) rbusy = ~rbusy;
          rcycle(0, 0, 8'($urandom), rbusy);
        end
        if ($urandom_range(0, 3) == 0) rbusy = ~rbusy;
        rcycle(0, 1, b, rbusy);
      end
      for (int g = $urandom_range(1, 2); g > 0; g--) begin
        if ($urandom_range(0, 3) == 0) rbusy = ~rbusy;
        rcycle(1, ($urandom_range(0, 4) == 0), 8'($urandom), rbusy);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
